// File: rtl/regfile_32x64.sv
// 32 x WIDTH register file: two combinational read ports with write-through
// bypass, one synchronous write port, and a hardwired zero register.

module decoder_5to32 (
    input  logic        en_i,
    input  logic [4:0]  addr_i,
    output logic [31:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[addr_i] = 1'b1;
        end
    end

endmodule

module regfile_32x64 #(
    parameter int WIDTH    = 64,
    parameter int ZERO_REG = 31
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             RegWrite,
    input  logic [4:0]       WriteRegister,
    input  logic [WIDTH-1:0] WriteData,
    input  logic [4:0]       ReadRegister1,
    input  logic [4:0]       ReadRegister2,
    output logic [WIDTH-1:0] ReadData1,
    output logic [WIDTH-1:0] ReadData2
);

    localparam logic [4:0] ZR = ZERO_REG[4:0];

    logic [31:0]      wen;
    logic [WIDTH-1:0] regs_q [32];

    decoder_5to32 u_dec (
        .en_i  (RegWrite),
        .addr_i(WriteRegister),
        .dec_o (wen)
    );

    // The zero index gets no flop; it is tied to 0 so reads need no special case.
    for (genvar i = 0; i < 32; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            assign regs_q[i] = '0;
        end else begin : g_flop
            logic [WIDTH-1:0] val_q;
            logic [WIDTH-1:0] val_d;

            always_comb begin
                val_d = val_q;
                if (wen[i]) begin
                    val_d = WriteData;
                end
            end

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    val_q <= '0;
                end else begin
                    val_q <= val_d;
                end
            end

            assign regs_q[i] = val_q;
        end
    end

    logic byp1;
    logic byp2;

    assign byp1 = RegWrite && (WriteRegister == ReadRegister1)
                  && (WriteRegister != ZR);
    assign byp2 = RegWrite && (WriteRegister == ReadRegister2)
                  && (WriteRegister != ZR);

    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (!reset) begin
            ReadData1 = byp1 ? WriteData : regs_q[ReadRegister1];
            ReadData2 = byp2 ? WriteData : regs_q[ReadRegister2];
        end
    end

endmodule
